// File: rtl/chunk_sequencer.sv
// Splits one WIDTH-bit word into NUM_OUT equal chunks and streams them LSB first
// over a valid/ready interface, counting fully delivered words.
module chunk_sequencer #(
   parameter int WIDTH     = 33,
   parameter int MAX_WIDTH = 11,
   // Smallest power-of-two chunk count whose ceil(WIDTH/n) fits in MAX_WIDTH
   localparam int NUM_OUT =
      (((WIDTH +    0) /    1) <= MAX_WIDTH) ?    1 :
      (((WIDTH +    1) /    2) <= MAX_WIDTH) ?    2 :
      (((WIDTH +    3) /    4) <= MAX_WIDTH) ?    4 :
      (((WIDTH +    7) /    8) <= MAX_WIDTH) ?    8 :
      (((WIDTH +   15) /   16) <= MAX_WIDTH) ?   16 :
      (((WIDTH +   31) /   32) <= MAX_WIDTH) ?   32 :
      (((WIDTH +   63) /   64) <= MAX_WIDTH) ?   64 :
      (((WIDTH +  127) /  128) <= MAX_WIDTH) ?  128 :
      (((WIDTH +  255) /  256) <= MAX_WIDTH) ?  256 :
      (((WIDTH +  511) /  512) <= MAX_WIDTH) ?  512 : 1024,
   localparam int CHUNK_W = (WIDTH + NUM_OUT - 1) / NUM_OUT,
   localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHUNK_W-1:0] out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   input  logic               flush,
   output logic [15:0]        words_done
);

   localparam int PAD_W = NUM_OUT * CHUNK_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [PAD_W-1:0]   capture;
   logic               armed;
   logic               is_last;
   logic               accept;

   assign is_last   = (idx == LAST_IDX);
   // armed keeps in_ready low until the first edge after reset release
   assign in_ready  = armed && !flush && ((state == IDLE) || (out_ready && is_last));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == SEND);
   assign out_last  = (state == SEND) && is_last;
   assign out_idx   = idx;

   always_comb begin
      out_data = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (idx == k[IDX_W-1:0]) out_data = capture[k*CHUNK_W +: CHUNK_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         capture    <= '0;
         armed      <= 1'b0;
         words_done <= '0;
      end else begin
         armed <= 1'b1;
         if (flush) begin
            state   <= IDLE;
            idx     <= '0;
            capture <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     capture <= PAD_W'(in_data);
                     idx     <= '0;
                     state   <= SEND;
                  end
               end
               SEND: begin
                  if (out_ready) begin
                     if (is_last) begin
                        words_done <= words_done + 16'd1;
                        idx        <= '0;
                        // Back-to-back capture avoids a bubble between words
                        if (accept) capture <= PAD_W'(in_data);
                        else        state   <= IDLE;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chunk_sequencer.sv
// Scoreboard bench for chunk_sequencer: default build (4 x 9-bit chunks) under
// directed and random traffic, plus an 8-bit single-chunk build for wrap checks.
module tb_chunk_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_last, flush;
   logic [32:0] in_data;
   logic [8:0]  out_data;
   logic [1:0]  out_idx;
   logic [15:0] words_done;

   logic        rst_nb;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_flush;
   logic [7:0]  b_in_data, b_out_data;
   logic [0:0]  b_out_idx;
   logic [15:0] b_words_done;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [8:0] data;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   exp_t        q[$];
   logic [15:0] exp_done;
   logic        armed;

   always #5 clk = ~clk;

   chunk_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .flush(flush), .words_done(words_done)
   );

   chunk_sequencer #(.WIDTH(8), .MAX_WIDTH(11)) dut_b (
      .clk(clk), .rst_n(rst_nb), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
      .flush(b_flush), .words_done(b_words_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // A word is usable only after one clock edge has been seen out of reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [35:0] padded;
      logic        exp_ready;
      exp_t        e;
      if (!rst_n) begin
         q.delete();
         exp_done = '0;
         chk("reset_outputs", {out_valid, out_last, out_idx, out_data, in_ready, words_done}, 64'd0);
      end else begin
         exp_ready = armed && !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
         chk("words_done", words_done, exp_done);
         chk("out_valid", out_valid, q.size() != 0);
         chk("in_ready", in_ready, exp_ready);
         if (out_valid && q.size() != 0)
            chk("chunk", {out_idx, out_last, out_data}, {q[0].idx, q[0].last, q[0].data});
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) begin
               e = q.pop_front();
               if (e.last) exp_done = exp_done + 16'd1;
            end
            if (in_valid && exp_ready) begin
               padded = {3'b000, in_data};
               for (int k = 0; k < 4; k++) begin
                  e.data = 9'((padded >> (9 * k)) & 36'h1FF);
                  e.idx  = 2'(k);
                  e.last = (k == 3);
                  q.push_back(e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [32:0] w);
      logic acc;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 50; i++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idx(input int v);
      for (int i = 0; i < 50; i++) begin
         if (out_valid && out_idx == 2'(v)) return;
         tick();
      end
      chk("wait_idx_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (!out_valid) return;
         tick();
      end
      chk("wait_idle_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; rst_nb = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1; rst_nb = 1'b1;

      // Single word, sink always ready
      out_ready = 1'b1;
      send(33'h1_2345_6789);
      wait_idle();

      // Same word with a three-cycle stall on chunk 1
      send(33'h1_2345_6789);
      wait_idx(1);
      out_ready = 1'b0;
      repeat (3) tick();
      chk("stall_hold", {out_valid, out_idx, out_data}, {1'b1, 2'd1, 9'h0B3});
      out_ready = 1'b1;
      wait_idle();

      // Two words back to back
      send(33'h0_DEAD_BEEF);
      send(33'h1_F0F0_0F0F);
      wait_idle();

      // Flush at chunk 2, then a fresh word
      send(33'h1_5555_AAAA);
      wait_idx(2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      send(33'h0_0123_4567);
      wait_idle();

      // Reset in the middle of a word
      send(33'h1_ABCD_EF01);
      wait_idx(1);
      rst_n = 1'b0;
      #1;
      chk("async_reset", {out_valid, out_last, out_idx, out_data, in_ready, words_done}, 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_reset", {in_ready, out_valid, words_done}, {1'b1, 1'b0, 16'd0});

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(9) < 7);
         in_data   = 33'({$urandom(), $urandom()});
         out_ready = ($urandom_range(9) < 7);
         flush     = ($urandom_range(31) == 0);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (10) tick();
      chk("drained", q.size(), 64'd0);

      // Single-chunk build: preload the counter and wrap it
      force dut_b.words_done = 16'hFFFF;
      #1;
      release dut_b.words_done;
      chk("b_preload", b_words_done, 16'hFFFF);
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_data   = 8'hA5;
      tick();
      b_in_valid = 1'b0;
      chk("b_chunk", {b_out_valid, b_out_last, b_out_idx, b_out_data, b_in_ready},
          {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0});
      b_out_ready = 1'b1;
      #1;
      chk("b_ready_on_last", b_in_ready, 1'b1);
      tick();
      chk("b_wrap", {b_out_valid, b_words_done}, {1'b0, 16'h0000});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
